mmu_req_arbiter: RTL and testbench
==================================

// Module: mmu_req_arbiter
// PURPOSE
//  Shares the single MMU translation port between NUM_REQ CPU-side requesters.
//  Round-robin grant; one transaction in flight at a time.
//  Drives valid_instr/CPU_write/address into the MMU and tracks MMU_ready to detect accept and completion.
//  Also reports per-transaction latency and page-fault counts.
// PARAMETERS
//  NUM_REQ      4    number of requesters (2..8)
//  ACK_TIMEOUT  16   max cycles to wait for MMU_ready to fall after issue
//  LAT_W        16   latency counter width
//  CNT_W        16   page-fault counter width
// PORTS
//  clk            in   1           clock
//  reset          in   1           reset, synchronous, active-high
//  req_valid      in   NUM_REQ     per-requester request; held high until its req_done
//  req_write      in   NUM_REQ     per-requester write flag
//  req_addr       in   NUM_REQ*32  per-requester address; slice i = [32*i+:32]
//  req_grant      out  NUM_REQ     one-hot; high from grant through completion
//  req_done       out  NUM_REQ     one-cycle pulse to the owner on completion
//  mmu_valid_instr out 1           to MMU valid_instr
//  mmu_cpu_write  out  1           to MMU CPU_write
//  mmu_address    out  32          to MMU address
//  mmu_ready      in   1           from MMU MMU_ready
//  mmu_page_fault in   1           from MMU page_fault (observe only)
//  busy           out  1           a transaction is owned
//  last_latency   out  LAT_W       cycles from issue to done of the last transaction
//  fault_count    out  CNT_W       saturating count of page-fault rising edges, all transactions
//  timeout_err    out  1           sticky; MMU failed to accept within ACK_TIMEOUT
// BEHAVIOUR
//  Reset: every output is 0; state=IDLE; rr_ptr=0; counters=0.
//  FSM states: IDLE, ISSUE, WAIT_DONE, DONE.
//  IDLE:
//   - If mmu_ready=1 and any req_valid: pick the first set bit scanning from rr_ptr upward, with wrap.
//   - Latch that requester's write and addr into regs; set req_grant and busy; go to ISSUE.
//   - Arbitration is decided in one cycle.
//  ISSUE:
//   - mmu_valid_instr=1, holding the latched write/addr; start lat_cnt=1.
//   - On mmu_ready=0 (accepted): drop valid_instr next cycle, go to WAIT_DONE.
//   - If ACK_TIMEOUT cycles elapse with mmu_ready still 1: set timeout_err; drop valid_instr for one cycle, then re-issue; req is not abandoned.
//  WAIT_DONE:
//   - mmu_valid_instr=0; lat_cnt increments, saturating.
//   - Each 0->1 edge of mmu_page_fault increments fault_count, saturating at all-ones.
//   - On mmu_ready=1, go to DONE.
//  DONE (1 cycle):
//   - req_done[owner]=1; last_latency<=lat_cnt; clear req_grant and busy.
//   - rr_ptr<=owner+1 mod NUM_REQ; go to IDLE.
//   - No new grant is made in the DONE cycle, so at least 1 idle cycle separates transactions.
//  Ordering:
//   - The owner's req_addr changing after grant has no effect; the latched copy is used.
//   - A requester that drops req_valid before its grant is simply not selected.
//   - If the owner drops req_valid mid-transaction, the transaction still completes and req_done still pulses.
//  Simultaneous events:
//   - A page-fault edge coinciding with mmu_ready=1 in WAIT_DONE is counted.
//   - Requests arriving during DONE are considered in the following IDLE.
//  Reset mid-operation: abort immediately to reset values. The MMU is reset on the same reset, so no drain is needed.
//  Latency: grant is 1 cycle after req_valid (when the MMU is idle); issue is 1 cycle later.
// STRUCTURE
//  Shared package (mmu_pkg): arb_state_t enum; the REQ index width function clog2(NUM_REQ).
//  Sub-module rr_picker (combinational): req vector + rr_ptr -> one-hot grant + index.
//  Everything else is in this module.
// TESTING
//  1. Single requester, NUM_REQ=4: req_valid=4'b0010, addr=0x0000_0014, MMU TLB hit
//     -> mmu_address=0x14, grant=4'b0010, one req_done[1] pulse, last_latency matches the MMU cycle count.
//  2. All four requesting continuously -> grant order 0,1,2,3,0; each done pulses exactly once per grant.
//  3. Request to an invalid page (VPN 1) -> fault_count increments by 1; the transaction still completes with req_done.
//  4. MMU model holds mmu_ready=1 and never accepts -> timeout_err=1 after 16 cycles; valid_instr re-asserts;
//     when the model later accepts, the transaction completes.
//  5. Reset asserted during WAIT_DONE -> next cycle all outputs are 0, state=IDLE, rr_ptr=0.
//  6. Owner changes req_addr from 0x8 to 0xC after grant -> the MMU sees 0x8 throughout.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared types for the MMU request arbiter slice.
// Holds the FSM state encoding and the index-width helper.
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    DONE
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or after ptr.
// Returns a one-hot grant, its index and whether anything was found.
module rr_picker
  import mmu_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mmu_req_arbiter.sv
// Shares one MMU translation port among NUM_REQ requesters, round-robin,
// one transaction in flight; reports latency, page faults and ack timeouts.
module mmu_req_arbiter
  import mmu_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int LAT_W       = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [NUM_REQ*32-1:0] req_addr,
  output logic [NUM_REQ-1:0]   req_grant,
  output logic [NUM_REQ-1:0]   req_done,
  output logic                 mmu_valid_instr,
  output logic                 mmu_cpu_write,
  output logic [31:0]          mmu_address,
  input  logic                 mmu_ready,
  input  logic                 mmu_page_fault,
  output logic                 busy,
  output logic [LAT_W-1:0]     last_latency,
  output logic [CNT_W-1:0]     fault_count,
  output logic                 timeout_err
);

  localparam int IW = clog2(NUM_REQ);
  localparam int AW = clog2(ACK_TIMEOUT);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               valid_q, valid_d;
  logic               write_q, write_d;
  logic [31:0]        addr_q, addr_d;
  logic               busy_q, busy_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [LAT_W-1:0]   last_lat_q, last_lat_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic               terr_q, terr_d;
  logic [AW-1:0]      ack_q, ack_d;
  logic               pf_q, pf_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [31:0]        sel_addr;
  logic               sel_write;
  logic [LAT_W-1:0]   lat_inc;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_addr  = req_addr[32*i +: 32];
        sel_write = req_write[i];
      end
    end
  end

  assign lat_inc = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    done_d     = '0;
    valid_d    = valid_q;
    write_d    = write_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    lat_d      = lat_q;
    last_lat_d = last_lat_q;
    fcnt_d     = fcnt_q;
    terr_d     = terr_q;
    ack_d      = ack_q;
    pf_d       = mmu_page_fault;

    if (state_q == WAIT_DONE && mmu_page_fault && !pf_q && fcnt_q != '1)
      fcnt_d = fcnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        lat_d = '0;
        if (mmu_ready && pick_any) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          write_d = sel_write;
          addr_d  = sel_addr;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!valid_q) begin
          // first issue starts latency at 1; a re-issue keeps counting
          valid_d = 1'b1;
          ack_d   = '0;
          lat_d   = (lat_q == '0) ? LAT_W'(1) : lat_inc;
        end else if (!mmu_ready) begin
          valid_d = 1'b0;
          lat_d   = lat_inc;
          state_d = WAIT_DONE;
        end else if (ack_q == AW'(ACK_TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          valid_d = 1'b0;
          lat_d   = lat_inc;
        end else begin
          ack_d = ack_q + AW'(1);
          lat_d = lat_inc;
        end
      end
      WAIT_DONE: begin
        lat_d = lat_inc;
        if (mmu_ready) begin
          done_d  = grant_q;
          state_d = DONE;
        end
      end
      DONE: begin
        last_lat_d = lat_q;
        grant_d    = '0;
        busy_d     = 1'b0;
        rr_d       = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      valid_q    <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      lat_q      <= '0;
      last_lat_q <= '0;
      fcnt_q     <= '0;
      terr_q     <= 1'b0;
      ack_q      <= '0;
      pf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      lat_q      <= lat_d;
      last_lat_q <= last_lat_d;
      fcnt_q     <= fcnt_d;
      terr_q     <= terr_d;
      ack_q      <= ack_d;
      pf_q       <= pf_d;
    end
  end

  assign req_grant       = grant_q;
  assign req_done        = done_q;
  assign mmu_valid_instr = valid_q;
  assign mmu_cpu_write   = write_q;
  assign mmu_address     = addr_q;
  assign busy            = busy_q;
  assign last_latency    = last_lat_q;
  assign fault_count     = fcnt_q;
  assign timeout_err     = terr_q;

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Directed bench for mmu_req_arbiter; the MMU side is driven step by step
// from the main sequence with hand-computed timing.
module tb_mmu_req_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [3:0]   req_grant;
  logic [3:0]   req_done;
  logic         mmu_valid_instr;
  logic         mmu_cpu_write;
  logic [31:0]  mmu_address;
  logic         mmu_ready;
  logic         mmu_page_fault;
  logic         busy;
  logic [15:0]  last_latency;
  logic [15:0]  fault_count;
  logic         timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  mmu_req_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_grant       (req_grant),
    .req_done        (req_done),
    .mmu_valid_instr (mmu_valid_instr),
    .mmu_cpu_write   (mmu_cpu_write),
    .mmu_address     (mmu_address),
    .mmu_ready       (mmu_ready),
    .mmu_page_fault  (mmu_page_fault),
    .busy            (busy),
    .last_latency    (last_latency),
    .fault_count     (fault_count),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (mmu_valid_instr === 1'b1) seen = 1'b1;
    end
    chk({tag, "_valid_seen"}, 64'(seen), 64'd1);
  endtask

  // called one cycle after valid_instr rose: accept, hold busy d cycles,
  // then complete, optionally with a page fault on the completion edge
  task automatic end_txn(input string tag, input int d, input bit fault,
                         input logic [3:0] exp_g, input logic [15:0] exp_lat,
                         input logic [15:0] exp_fc);
    tick();
    mmu_ready = 1'b0;
    repeat (d) tick();
    mmu_ready      = 1'b1;
    mmu_page_fault = fault;
    tick();
    mmu_page_fault = 1'b0;
    chk({tag, "_done"}, 64'(req_done), 64'(exp_g));
    chk({tag, "_grant_in_done"}, 64'(req_grant), 64'(exp_g));
    chk({tag, "_fault_count"}, 64'(fault_count), 64'(exp_fc));
    tick();
    chk({tag, "_done_pulse"}, 64'(req_done), 64'd0);
    chk({tag, "_grant_clr"}, 64'(req_grant), 64'd0);
    chk({tag, "_busy_clr"}, 64'(busy), 64'd0);
    chk({tag, "_latency"}, 64'(last_latency), 64'(exp_lat));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mmu_ready = 1'b1;
    mmu_page_fault = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = '0;
    req_write      = '0;
    req_addr       = '0;
    mmu_ready      = 1'b1;
    mmu_page_fault = 1'b0;
    do_reset();

    chk("rst_grant", 64'(req_grant), 64'd0);
    chk("rst_done", 64'(req_done), 64'd0);
    chk("rst_valid", 64'(mmu_valid_instr), 64'd0);
    chk("rst_addr", 64'(mmu_address), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lat", 64'(last_latency), 64'd0);
    chk("rst_fcnt", 64'(fault_count), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);

    // single requester, TLB hit
    req_valid = 4'b0010;
    req_write = 4'b0010;
    req_addr[32*1 +: 32] = 32'h0000_0014;
    tick();
    chk("t1_grant", 64'(req_grant), 64'b0010);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_valid_late", 64'(mmu_valid_instr), 64'd0);
    wait_valid("t1");
    chk("t1_addr", 64'(mmu_address), 64'h14);
    chk("t1_write", 64'(mmu_cpu_write), 64'd1);
    end_txn("t1", 1, 1'b0, 4'b0010, 16'd4, 16'd0);
    req_valid = '0;
    req_write = '0;

    // page fault on VPN 1, raised together with ready
    req_valid = 4'b0001;
    req_addr[32*0 +: 32] = 32'h0000_1040;
    tick();
    wait_valid("t3");
    chk("t3_addr", 64'(mmu_address), 64'h1040);
    end_txn("t3", 2, 1'b1, 4'b0001, 16'd5, 16'd1);
    req_valid = '0;

    // MMU never accepts for a while: timeout, drop, re-issue
    req_valid = 4'b1000;
    req_addr[32*3 +: 32] = 32'h0000_2000;
    tick();
    wait_valid("t4");
    repeat (15) tick();
    chk("t4_valid_held", 64'(mmu_valid_instr), 64'd1);
    chk("t4_terr_early", 64'(timeout_err), 64'd0);
    tick();
    chk("t4_terr", 64'(timeout_err), 64'd1);
    chk("t4_valid_drop", 64'(mmu_valid_instr), 64'd0);
    tick();
    chk("t4_reissue", 64'(mmu_valid_instr), 64'd1);
    chk("t4_busy", 64'(busy), 64'd1);
    end_txn("t4", 2, 1'b0, 4'b1000, 16'd22, 16'd1);
    chk("t4_terr_sticky", 64'(timeout_err), 64'd1);
    req_valid = '0;

    do_reset();

    // address latched at grant
    req_valid = 4'b0001;
    req_addr[32*0 +: 32] = 32'h0000_0008;
    tick();
    chk("t6_grant", 64'(req_grant), 64'b0001);
    req_addr[32*0 +: 32] = 32'h0000_000C;
    wait_valid("t6");
    chk("t6_addr_issue", 64'(mmu_address), 64'h8);
    end_txn("t6", 3, 1'b0, 4'b0001, 16'd6, 16'd0);
    chk("t6_addr_after", 64'(mmu_address), 64'h8);
    req_valid = '0;

    // reset in WAIT_DONE, after moving rr_ptr to 3
    req_valid = 4'b0100;
    req_addr[32*2 +: 32] = 32'h0000_0030;
    tick();
    wait_valid("t5a");
    end_txn("t5a", 1, 1'b0, 4'b0100, 16'd4, 16'd0);
    wait_valid("t5b");
    tick();
    mmu_ready = 1'b0;
    tick();
    chk("t5_pre_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    mmu_ready = 1'b1;
    req_valid = 4'b1111;
    tick();
    reset = 1'b0;
    chk("t5_grant", 64'(req_grant), 64'd0);
    chk("t5_done", 64'(req_done), 64'd0);
    chk("t5_valid", 64'(mmu_valid_instr), 64'd0);
    chk("t5_addr", 64'(mmu_address), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_lat", 64'(last_latency), 64'd0);

    // all four requesting: order must restart at 0
    req_write = '0;
    for (int i = 0; i < 4; i++) req_addr[32*i +: 32] = 32'h100 + 32'(4*i);
    for (int k = 0; k < 5; k++) begin
      logic [3:0]  eg;
      logic [31:0] ea;
      eg = 4'b0001 << (k % 4);
      ea = 32'h100 + 32'(4*(k % 4));
      wait_valid("t2");
      chk("t2_grant", 64'(req_grant), 64'(eg));
      chk("t2_addr", 64'(mmu_address), 64'(ea));
      end_txn("t2", 2, 1'b0, eg, 16'd5, 16'd0);
    end
    req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
